// File: rtl/ysyx_22040729_ifu_fetch.sv
// Instruction fetch unit: owns the architectural PC, issues one instruction read at a
// time and hands {pc, inst, fault} to decode; redirects discard stale fetches.
module ysyx_22040729_ifu_fetch #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64,
    parameter int INST_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_ADDR = 64'h8000_0000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  imem_req_valid,
    input  logic                  imem_req_ready,
    output logic [ADDR_WIDTH-1:0] imem_req_addr,
    input  logic                  imem_resp_valid,
    output logic                  imem_resp_ready,
    input  logic [DATA_WIDTH-1:0] imem_resp_data,
    input  logic                  imem_resp_err,
    output logic                  if_valid,
    input  logic                  if_ready,
    output logic [ADDR_WIDTH-1:0] if_pc,
    output logic [INST_WIDTH-1:0] if_inst,
    output logic                  if_fault
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD} state_t;

    state_t                state, state_n;
    logic [ADDR_WIDTH-1:0] pc, pc_n;
    logic                  drop, drop_n;
    logic [ADDR_WIDTH-1:0] req_addr_n;
    logic [ADDR_WIDTH-1:0] if_pc_n;
    logic [INST_WIDTH-1:0] if_inst_n;
    logic                  if_fault_n;
    logic                  launch;
    logic [ADDR_WIDTH-1:0] launch_pc;
    logic [ADDR_WIDTH-1:0] tgt_pc;
    logic [INST_WIDTH-1:0] resp_word;

    assign tgt_pc    = redirect_valid ? redirect_pc : pc;
    assign resp_word = pc[2] ? imem_resp_data[63:32] : imem_resp_data[31:0];

    always_comb begin
        state_n    = state;
        pc_n       = pc;
        drop_n     = drop;
        req_addr_n = imem_req_addr;
        if_pc_n    = if_pc;
        if_inst_n  = if_inst;
        if_fault_n = if_fault;
        launch     = 1'b0;
        launch_pc  = tgt_pc;

        if (redirect_valid) begin
            pc_n = redirect_pc;
        end

        case (state)
            S_IDLE: launch = 1'b1;
            S_REQ: begin
                // the bus request cannot be withdrawn, so a redirect only marks it stale
                drop_n = drop | redirect_valid;
                if (imem_req_valid && imem_req_ready) begin
                    state_n = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_resp_valid) begin
                    if (drop || redirect_valid) begin
                        drop_n = 1'b0;
                        launch = 1'b1;
                    end else begin
                        state_n    = S_HOLD;
                        if_pc_n    = pc;
                        if_inst_n  = resp_word;
                        if_fault_n = imem_resp_err;
                    end
                end else if (redirect_valid) begin
                    drop_n = 1'b1;
                end
            end
            S_HOLD: begin
                if (redirect_valid) begin
                    launch = 1'b1;
                end else if (if_ready) begin
                    pc_n      = pc + ADDR_WIDTH'(4);
                    launch_pc = pc + ADDR_WIDTH'(4);
                    launch    = 1'b1;
                end
            end
            default: state_n = S_IDLE;
        endcase

        // a misaligned fetch address never reaches the bus; it is reported as a fault
        if (launch) begin
            if (launch_pc[1:0] != 2'b00) begin
                state_n    = S_HOLD;
                if_pc_n    = launch_pc;
                if_inst_n  = '0;
                if_fault_n = 1'b1;
            end else begin
                state_n    = S_REQ;
                req_addr_n = launch_pc;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state           <= S_IDLE;
            pc              <= RESET_ADDR;
            drop            <= 1'b0;
            imem_req_addr   <= RESET_ADDR;
            imem_req_valid  <= 1'b0;
            imem_resp_ready <= 1'b0;
            if_valid        <= 1'b0;
            if_pc           <= '0;
            if_inst         <= '0;
            if_fault        <= 1'b0;
        end else begin
            state           <= state_n;
            pc              <= pc_n;
            drop            <= drop_n;
            imem_req_addr   <= req_addr_n;
            imem_req_valid  <= (state_n == S_REQ);
            imem_resp_ready <= (state_n == S_WAIT);
            if_valid        <= (state_n == S_HOLD);
            if_pc           <= if_pc_n;
            if_inst         <= if_inst_n;
            if_fault        <= if_fault_n;
        end
    end

endmodule

// File: tb/tb_ysyx_22040729_ifu_fetch.sv
// Bench for ysyx_22040729_ifu_fetch: directed scenarios plus randomized traffic checked
// against an instruction-stream model (expected PC sequence and a fixed memory image).
module tb_ysyx_22040729_ifu_fetch;

    localparam logic [63:0] RST_A = 64'h8000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [63:0] imem_req_addr;
    logic        imem_resp_valid;
    logic        imem_resp_ready;
    logic [63:0] imem_resp_data;
    logic        imem_resp_err;
    logic        if_valid;
    logic        if_ready;
    logic [63:0] if_pc;
    logic [31:0] if_inst;
    logic        if_fault;

    always #5 clk = ~clk;

    ysyx_22040729_ifu_fetch #(
        .ADDR_WIDTH(64),
        .DATA_WIDTH(64),
        .INST_WIDTH(32),
        .RESET_ADDR(RST_A)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_resp_valid(imem_resp_valid),
        .imem_resp_ready(imem_resp_ready),
        .imem_resp_data (imem_resp_data),
        .imem_resp_err  (imem_resp_err),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_pc          (if_pc),
        .if_inst        (if_inst),
        .if_fault       (if_fault)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // memory image: fixed words at the reset vector, an address-derived pattern elsewhere
    function automatic logic [63:0] mem_data(input logic [63:0] a);
        logic [63:0] al;
        al = {a[63:3], 3'b000};
        if (al == 64'h8000_0000) return 64'h00000013_00100093;
        return {al[31:0] ^ 32'h0F1E_2D3C, al[31:0] ^ 32'hDEAD_BEEF};
    endfunction

    function automatic logic mem_err(input logic [63:0] a);
        logic [63:0] al;
        al = {a[63:3], 3'b000};
        return (al == 64'h8000_0008) || (al[8:3] == 6'h2A);
    endfunction

    function automatic logic [31:0] exp_inst(input logic [63:0] pc);
        logic [63:0] d;
        if (pc[1:0] != 2'b00) return 32'h0;
        d = mem_data(pc);
        return pc[2] ? d[63:32] : d[31:0];
    endfunction

    function automatic logic exp_fault(input logic [63:0] pc);
        return (pc[1:0] != 2'b00) || mem_err(pc);
    endfunction

    // stimulus controls
    logic        drv_if_ready = 1'b0;
    logic        drv_redir    = 1'b0;
    logic [63:0] drv_redir_pc = '0;
    int          rdy_mode     = 0;   // 0 always ready, 1 never, 2 random
    int          lat          = 0;   // response latency, negative = random 0..3

    // memory and model state
    logic        pending    = 1'b0;
    logic [63:0] pend_addr  = '0;
    int          pend_cnt   = 0;
    logic [63:0] exp_pc     = RST_A;
    logic        prev_stall = 1'b0;
    logic [63:0] prev_addr  = '0;

    // drive inputs for the coming posedge, advance to the next negedge, then check outputs
    task automatic tick();
        logic r;
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
        imem_resp_err   = 1'b0;
        if (rst) begin
            if (pending) begin
                if (pend_cnt == 0 && imem_resp_ready) begin
                    imem_resp_valid = 1'b1;
                    imem_resp_data  = mem_data(pend_addr);
                    imem_resp_err   = mem_err(pend_addr);
                    pending         = 1'b0;
                end else if (pend_cnt > 0) begin
                    pend_cnt--;
                end
            end else if (rdy_mode == 2 && !imem_resp_ready && $urandom_range(7) == 0) begin
                imem_resp_valid = 1'b1;
                imem_resp_data  = {$urandom, $urandom};
                imem_resp_err   = 1'b1;
            end
            if (rdy_mode == 0)      r = 1'b1;
            else if (rdy_mode == 1) r = 1'b0;
            else                    r = ($urandom_range(1) == 1);
            imem_req_ready = r;
            if (imem_req_valid && r) begin
                pending   = 1'b1;
                pend_addr = imem_req_addr;
                pend_cnt  = (lat < 0) ? int'($urandom_range(3)) : lat;
            end
            prev_stall     = imem_req_valid && !r;
            prev_addr      = imem_req_addr;
            if_ready       = drv_if_ready;
            redirect_valid = drv_redir;
            redirect_pc    = drv_redir_pc;
            if (drv_redir) exp_pc = drv_redir_pc;
            else if (if_valid && drv_if_ready) exp_pc = exp_pc + 64'd4;
            drv_redir = 1'b0;
        end
        @(negedge clk);
        if (rst) begin
            if (if_valid) begin
                check("m_if_pc", if_pc, exp_pc);
                check("m_if_inst", 64'(if_inst), 64'(exp_inst(exp_pc)));
                check("m_if_fault", 64'(if_fault), 64'(exp_fault(exp_pc)));
            end
            if (imem_req_valid) begin
                check("m_req_excl", 64'(if_valid), 64'd0);
                check("m_req_align", 64'(imem_req_addr[1:0]), 64'd0);
            end
            if (prev_stall) begin
                check("m_req_hold_valid", 64'(imem_req_valid), 64'd1);
                check("m_req_hold_addr", imem_req_addr, prev_addr);
            end
        end
    endtask

    task automatic wait_req(input string tag, input logic [63:0] addr);
        int n = 0;
        while (!imem_req_valid && n < 40) begin tick(); n++; end
        check({tag, "_seen"}, 64'(imem_req_valid), 64'd1);
        check(tag, imem_req_addr, addr);
    endtask

    task automatic wait_if(input string tag, input logic [63:0] pc, input logic [31:0] inst,
                           input logic fault, output int n);
        n = 0;
        while (!if_valid && n < 40) begin tick(); n++; end
        check({tag, "_seen"}, 64'(if_valid), 64'd1);
        check({tag, "_pc"}, if_pc, pc);
        check({tag, "_inst"}, 64'(if_inst), 64'(inst));
        check({tag, "_fault"}, 64'(if_fault), 64'(fault));
    endtask

    task automatic wait_resp_ready(input string tag);
        int n = 0;
        while (!imem_resp_ready && n < 40) begin tick(); n++; end
        check(tag, 64'(imem_resp_ready), 64'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_valid"}, 64'(imem_req_valid), 64'd0);
        check({tag, "_resp_ready"}, 64'(imem_resp_ready), 64'd0);
        check({tag, "_if_valid"}, 64'(if_valid), 64'd0);
        check({tag, "_if_pc"}, if_pc, 64'd0);
        check({tag, "_if_inst"}, 64'(if_inst), 64'd0);
        check({tag, "_if_fault"}, 64'(if_fault), 64'd0);
        check({tag, "_req_addr"}, imem_req_addr, RST_A);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout got=%0t exp=finish", $time);
        $fatal(1, "bench timeout");
    end

    initial begin
        int n;
        int gap;
        int max_gap;
        int nacc;
        logic [63:0] hold_a;
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
        imem_resp_err   = 1'b0;
        if_ready        = 1'b0;
        redirect_valid  = 1'b0;
        redirect_pc     = '0;

        // reset state
        repeat (2) @(negedge clk);
        check_reset_outputs("rst");
        rst = 1'b1;

        // basic fetch from the reset vector
        tick();
        check("t1_req_valid", 64'(imem_req_valid), 64'd1);
        check("t1_req_addr0", imem_req_addr, RST_A);
        wait_if("t1_i0", RST_A, 32'h0010_0093, 1'b0, n);
        check("t1_latency", 64'(n), 64'd2);

        // decode stalls: everything held, no new request
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t2_valid", 64'(if_valid), 64'd1);
            check("t2_pc", if_pc, RST_A);
            check("t2_inst", 64'(if_inst), 64'h0010_0093);
            check("t2_noreq", 64'(imem_req_valid), 64'd0);
        end
        drv_if_ready = 1'b1;
        tick();
        drv_if_ready = 1'b0;
        wait_req("t1_req_addr1", 64'h8000_0004);
        wait_if("t1_i1", 64'h8000_0004, 32'h0000_0013, 1'b0, n);

        // bus error, then misaligned redirect
        drv_if_ready = 1'b1;
        tick();
        drv_if_ready = 1'b0;
        wait_if("t5_err", 64'h8000_0008, 32'h5EAD_BEE7, 1'b1, n);
        drv_redir    = 1'b1;
        drv_redir_pc = 64'h8000_0002;
        for (int i = 0; i < 2; i++) begin
            tick();
            check("t5_mis_valid", 64'(if_valid), 64'd1);
            check("t5_mis_pc", if_pc, 64'h8000_0002);
            check("t5_mis_inst", 64'(if_inst), 64'd0);
            check("t5_mis_fault", 64'(if_fault), 64'd1);
            check("t5_mis_noreq", 64'(imem_req_valid), 64'd0);
        end

        // redirect while waiting on a slow response
        lat          = 3;
        drv_redir    = 1'b1;
        drv_redir_pc = 64'h8000_0100;
        tick();
        wait_resp_ready("t3_in_wait");
        drv_redir    = 1'b1;
        drv_redir_pc = 64'h8000_1000;
        n = 0;
        do begin
            tick();
            check("t3_no_if", 64'(if_valid), 64'd0);
            n++;
        end while (!imem_req_valid && n < 20);
        check("t3_req_seen", 64'(imem_req_valid), 64'd1);
        check("t3_req_addr", imem_req_addr, 64'h8000_1000);
        lat = 0;
        wait_if("t3_i", 64'h8000_1000, 32'h5EAD_AEEF, 1'b0, n);

        // redirect while the request is back-pressured
        rdy_mode     = 1;
        drv_if_ready = 1'b1;
        tick();
        drv_if_ready = 1'b0;
        wait_req("t4_req", 64'h8000_1004);
        hold_a       = imem_req_addr;
        drv_redir    = 1'b1;
        drv_redir_pc = 64'h8000_2000;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t4_hold_valid", 64'(imem_req_valid), 64'd1);
            check("t4_hold_addr", imem_req_addr, 64'h8000_1004);
        end
        rdy_mode = 0;
        n = 0;
        do begin
            tick();
            check("t4_no_if", 64'(if_valid), 64'd0);
            n++;
        end while (!(imem_req_valid && imem_req_addr != hold_a) && n < 20);
        check("t4_req_seen", 64'(imem_req_valid), 64'd1);
        check("t4_req_addr", imem_req_addr, 64'h8000_2000);
        wait_if("t4_i", 64'h8000_2000, 32'h5EAD_9EEF, 1'b0, n);

        // asynchronous reset in the middle of a transaction
        lat          = 5;
        drv_if_ready = 1'b1;
        tick();
        drv_if_ready = 1'b0;
        wait_resp_ready("t6_in_wait");
        #2;
        rst             = 1'b0;
        pending         = 1'b0;
        prev_stall      = 1'b0;
        exp_pc          = RST_A;
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b0;
        #1;
        check_reset_outputs("t6_rst");
        @(negedge clk);
        rst = 1'b1;
        lat = 0;
        wait_req("t6_restart", RST_A);
        wait_if("t6_i0", RST_A, 32'h0010_0093, 1'b0, n);

        // PC wraps past the top of the address space
        drv_redir    = 1'b1;
        drv_redir_pc = 64'hFFFF_FFFF_FFFF_FFFC;
        tick();
        wait_if("t6_top", 64'hFFFF_FFFF_FFFF_FFFC, 32'hF0E1_D2C4, 1'b0, n);
        drv_if_ready = 1'b1;
        tick();
        drv_if_ready = 1'b0;
        wait_req("t6_wrap", 64'h0);

        // randomized traffic against the stream model
        rdy_mode = 2;
        lat      = -1;
        gap      = 0;
        max_gap  = 0;
        nacc     = 0;
        for (int i = 0; i < 1500; i++) begin
            drv_if_ready = ($urandom_range(3) != 0);
            if ($urandom_range(15) == 0) begin
                drv_redir    = 1'b1;
                drv_redir_pc = 64'h8000_0000 + 64'({$urandom_range(1023), 2'b00});
                if ($urandom_range(7) == 0) drv_redir_pc[1:0] = 2'($urandom_range(3));
            end
            if (if_valid && drv_if_ready) nacc++;
            tick();
            if (if_valid) gap = 0;
            else gap++;
            if (gap > max_gap) max_gap = gap;
        end
        check("rnd_max_gap_ok", 64'(max_gap <= 64), 64'd1);
        check("rnd_progress_ok", 64'(nacc >= 100), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
